multicycle_control: RTL and testbench

Multi-cycle sequencer for the shared MIPS-subset datapath. One ALU and one unified instruction/data memory port are reused across several cycles per instruction. The block is a Moore FSM with a few gated Mealy strobes. It sits beside the datapath, takes the latched IR opcode, the ALU `zero` flag and the memory `mem_ready` handshake, and drives every datapath mux and write enable.

---
 rtl/multicycle_control_pkg.sv | 56 +++++
 rtl/multicycle_control_opdecode.sv | 27 ++
 rtl/multicycle_control.sv | 155 +++++++++++++++
 tb/tb_multicycle_control.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle sequencer: state codes, opcodes,
// datapath mux encodings and the opcode-class decode record.
package multicycle_control_pkg;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR = 4'd2;
  localparam logic [3:0] ST_MEM_RD   = 4'd3;
  localparam logic [3:0] ST_MEM_WB   = 4'd4;
  localparam logic [3:0] ST_MEM_WR   = 4'd5;
  localparam logic [3:0] ST_R_EX     = 4'd6;
  localparam logic [3:0] ST_R_WB     = 4'd7;
  localparam logic [3:0] ST_BRANCH   = 4'd8;
  localparam logic [3:0] ST_JUMP     = 4'd9;
  localparam logic [3:0] ST_I_EX     = 4'd10;
  localparam logic [3:0] ST_I_WB     = 4'd11;
  localparam logic [3:0] ST_HALT     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    CLS_MEM,
    CLS_RTYPE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_IMM,
    CLS_ILLEGAL
  } op_class_e;

  typedef struct packed {
    op_class_e cls;
    logic      is_load;  // lw vs sw within CLS_MEM
    logic      is_bne;   // bne vs beq within CLS_BRANCH
    logic      illegal;
  } op_dec_t;

endpackage

// File: rtl/multicycle_control_opdecode.sv
// Combinational opcode -> instruction class decoder. The IR opcode is stable
// from DECODE onward, so later states reuse the same decode result.
module multicycle_control_opdecode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode,
  output op_dec_t    dec
);

  always_comb begin
    dec.cls     = CLS_ILLEGAL;
    dec.is_load = 1'b0;
    dec.is_bne  = 1'b0;
    dec.illegal = 1'b1;
    case (opcode)
      OP_RTYPE: begin dec.cls = CLS_RTYPE;  dec.illegal = 1'b0; end
      OP_J:     begin dec.cls = CLS_JUMP;   dec.illegal = 1'b0; end
      OP_BEQ:   begin dec.cls = CLS_BRANCH; dec.illegal = 1'b0; end
      OP_BNE:   begin dec.cls = CLS_BRANCH; dec.is_bne = 1'b1; dec.illegal = 1'b0; end
      OP_ADDIU: begin dec.cls = CLS_IMM;    dec.illegal = 1'b0; end
      OP_LW:    begin dec.cls = CLS_MEM;    dec.is_load = 1'b1; dec.illegal = 1'b0; end
      OP_SW:    begin dec.cls = CLS_MEM;    dec.illegal = 1'b0; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset sequencer: Moore FSM driving the shared datapath,
// with FETCH/MEM_WR/BRANCH strobes gated by mem_ready and zero.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       ext_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  logic [3:0] state_q, state_d;
  logic       illegal_q;
  op_dec_t    dec;

  multicycle_control_opdecode u_opdecode (
    .opcode (opcode),
    .dec    (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | ((state_q == ST_DECODE) & dec.illegal);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (dec.cls)
          CLS_MEM:    state_d = ST_MEM_ADDR;
          CLS_RTYPE:  state_d = ST_R_EX;
          CLS_BRANCH: state_d = ST_BRANCH;
          CLS_JUMP:   state_d = ST_JUMP;
          CLS_IMM:    state_d = ST_I_EX;
          default:    state_d = ST_HALT;
        endcase
      end
      ST_MEM_ADDR: state_d = dec.is_load ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_R_EX:     state_d = ST_R_WB;
      ST_I_EX:     state_d = ST_I_WB;
      ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      // unused encodings fall back to a clean fetch
      default:     state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PCS_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_FOUR;
    alu_op     = ALU_ADD;
    ext_op     = 1'b1;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
      end
      ST_R_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      ST_I_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b0;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_SUB;
        pc_source = PCS_ALUOUT;
        pc_write  = dec.is_bne ? ~zero : zero;
        retire    = 1'b1;
      end
      ST_JUMP: begin
        pc_source = PCS_JUMP;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: a per-instruction phase model built from
// the opcode and chosen wait counts is compared cycle by cycle with the DUT.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero, mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic       alu_src_a, ext_op, reg_dst, mem_to_reg, reg_write, retire, illegal;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, REX = 6, RWB = 7,
                 BR = 8, JMP = 9, IEX = 10, IWB = 11, HLT = 12;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ext_op(ext_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .retire(retire), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end

  // Expected phase sequence of one instruction given fetch/memory wait counts.
  task automatic build(input logic [5:0] op, input int wf, input int wm, output int q[$]);
    q = {};
    for (int k = 0; k <= wf; k++) q.push_back(F);
    q.push_back(D);
    case (op)
      6'h23: begin q.push_back(MA); for (int k = 0; k <= wm; k++) q.push_back(MR); q.push_back(MWB); end
      6'h2B: begin q.push_back(MA); for (int k = 0; k <= wm; k++) q.push_back(MW); end
      6'h00: begin q.push_back(REX); q.push_back(RWB); end
      6'h09: begin q.push_back(IEX); q.push_back(IWB); end
      6'h04, 6'h05: q.push_back(BR);
      6'h02: q.push_back(JMP);
      default: q.push_back(HLT);
    endcase
  endtask

  // Enter at a negedge with the DUT in FETCH; leave at a negedge after the instruction.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int zmode,
                           output int cycles, output int retires, output logic br_pcw);
    int q[$];
    int st;
    bit req, last;
    logic [5:0] ev, av;
    logic [2:0] ealu;
    build(op, wf, wm, q);
    cycles = 0; retires = 0; br_pcw = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      st   = q[i];
      req  = (st == F) || (st == MR) || (st == MW);
      last = (i == q.size() - 1) ? 1'b1 : (q[i+1] != st);
      opcode    = op;
      mem_ready = req ? last : 1'($urandom_range(0, 1));
      zero      = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      // expected {mem_read, mem_write, ir_write, pc_write, reg_write, retire}
      ev = '0;
      case (st)
        F:   ev = {1'b1, 1'b0, mem_ready, mem_ready, 2'b00};
        MR:  ev = 6'b100000;
        MW:  ev = {1'b0, 1'b1, 3'b000, mem_ready};
        MWB, RWB, IWB: ev = 6'b000011;
        BR:  ev = {3'b000, (op == 6'h04) ? zero : ~zero, 1'b0, 1'b1};
        JMP: ev = 6'b000101;
        default: ev = '0;
      endcase
      av = {mem_read, mem_write, ir_write, pc_write, reg_write, retire};
      n_checks++;
      if (state !== 4'(st)) begin
        n_fail++; $display("FAIL state op=%h cyc=%0d: got %0d want %0d", op, i, state, st);
      end
      n_checks++;
      if (av !== ev) begin
        n_fail++; $display("FAIL strobes op=%h cyc=%0d: got %b want %b", op, i, av, ev);
      end
      n_checks++;
      if (illegal !== (st == HLT)) begin
        n_fail++; $display("FAIL illegal op=%h cyc=%0d: got %b want %b", op, i, illegal, st == HLT);
      end
      if (ev[5] | ev[4]) begin
        n_checks++;
        if (i_or_d !== (st != F)) begin
          n_fail++; $display("FAIL i_or_d op=%h cyc=%0d: got %b want %b", op, i, i_or_d, st != F);
        end
      end
      if (ev[1]) begin
        n_checks++;
        if ({reg_dst, mem_to_reg} !== {st == RWB, st == MWB}) begin
          n_fail++; $display("FAIL wb_sel op=%h cyc=%0d: got %b%b want %b%b", op, i,
                             reg_dst, mem_to_reg, st == RWB, st == MWB);
        end
      end
      if (ev[2] || st == BR) begin
        n_checks++;
        if (pc_source !== ((st == F) ? 2'b00 : (st == BR) ? 2'b01 : 2'b10)) begin
          n_fail++; $display("FAIL pc_source op=%h cyc=%0d: got %b", op, i, pc_source);
        end
      end
      // expected {alu_src_a, alu_src_b} where the datapath actually uses the ALU
      if (st == F || st == D || st == MA || st == REX || st == IEX || st == BR) begin
        ealu = (st == F) ? 3'b001 : (st == D) ? 3'b011 : (st == MA || st == IEX) ? 3'b110 : 3'b100;
        n_checks++;
        if ({alu_src_a, alu_src_b} !== ealu) begin
          n_fail++; $display("FAIL alu_src op=%h cyc=%0d: got %b want %b", op, i, {alu_src_a, alu_src_b}, ealu);
        end
        if (st != D) begin
          n_checks++;
          if (alu_op !== ((st == REX) ? 2'b10 : (st == BR) ? 2'b01 : 2'b00)) begin
            n_fail++; $display("FAIL alu_op op=%h cyc=%0d: got %b", op, i, alu_op);
          end
        end
        if (st == D || st == MA || st == IEX) begin
          n_checks++;
          if (ext_op !== (st != IEX)) begin
            n_fail++; $display("FAIL ext_op op=%h cyc=%0d: got %b want %b", op, i, ext_op, st != IEX);
          end
        end
      end
      if (retire === 1'b1) retires++;
      if (st == BR) br_pcw = pc_write;
      cycles++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  function automatic int cpi(input logic [5:0] op, input int wf, input int wm);
    case (op)
      6'h00, 6'h09: return 4 + wf;
      6'h23:        return 5 + wf + wm;
      6'h2B:        return 4 + wf + wm;
      default:      return 3 + wf;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got state=%0d illegal=%b want 0/0", state, illegal);
    end
    n_checks++;
    if ({mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, retire} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 1000000",
                         {mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, retire});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_addiu();
    int c, r; logic b;
    run_instr(6'h09, 0, 0, -1, c, r, b);
    n_checks++;
    if (c !== 4 || r !== 1) begin
      n_fail++; $display("FAIL addiu_cpi: got cycles=%0d retires=%0d want 4/1", c, r);
    end
  endtask

  task automatic test_lw_wait();
    int c, r; logic b;
    run_instr(6'h23, 0, 2, -1, c, r, b);
    n_checks++;
    if (c !== 7 || r !== 1) begin
      n_fail++; $display("FAIL lw_wait_cpi: got cycles=%0d retires=%0d want 7/1", c, r);
    end
  endtask

  task automatic test_branch();
    int c, r; logic b;
    for (int k = 0; k < 4; k++) begin
      logic [5:0] op;
      logic z, want;
      op   = (k < 2) ? 6'h04 : 6'h05;
      z    = k[0];
      want = (op == 6'h04) ? z : ~z;
      run_instr(op, k, 0, int'(z), c, r, b);
      n_checks++;
      if (b !== want || c !== 3 + k) begin
        n_fail++; $display("FAIL branch op=%h zero=%b: got pc_write=%b cycles=%0d want %b/%0d",
                           op, z, b, c, want, 3 + k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c1, r1, c2, r2; logic b;
    run_instr(6'h2B, 0, 1, -1, c1, r1, b);
    run_instr(6'h02, 0, 0, -1, c2, r2, b);
    n_checks++;
    if (r1 + r2 !== 2 || c1 + c2 !== 8) begin
      n_fail++; $display("FAIL sw_j_b2b: got retires=%0d cycles=%0d want 2/8", r1 + r2, c1 + c2);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    int c, r, wf, wm; logic b;
    logic [5:0] op;
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h09, 6'h23, 6'h2B};
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 6)];
      wf = $urandom_range(0, 3);
      wm = $urandom_range(0, 3);
      run_instr(op, wf, wm, -1, c, r, b);
      n_checks++;
      if (c !== cpi(op, wf, wm) || r !== 1) begin
        n_fail++; $display("FAIL random_cpi op=%h wf=%0d wm=%0d: got %0d/%0d want %0d/1",
                           op, wf, wm, c, r, cpi(op, wf, wm));
      end
    end
  endtask

  task automatic test_illegal();
    int c, r; logic b;
    run_instr(6'h3F, 0, 0, -1, c, r, b);
    n_checks++;
    if (r !== 0) begin
      n_fail++; $display("FAIL illegal_retire: got %0d want 0", r);
    end
    for (int k = 0; k < 10; k++) begin
      mem_ready = k[0];
      zero      = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (state !== 4'd12 || illegal !== 1'b1 ||
          {mem_read, mem_write, ir_write, pc_write, reg_write, retire} !== 6'b0) begin
        n_fail++; $display("FAIL halt_hold k=%0d: got state=%0d illegal=%b strobes=%b want 12/1/000000",
                           k, state, illegal, {mem_read, mem_write, ir_write, pc_write, reg_write, retire});
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int c, r; logic b;
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_from_halt: got state=%0d illegal=%b want 0/0", state, illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    opcode = 6'h2B; mem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    #1;
    n_checks++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      n_fail++; $display("FAIL sw_wait: got state=%0d mem_write=%b want 5/1", state, mem_write);
    end
    @(posedge clk); @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (state !== 4'd0 || mem_write !== 1'b0 || mem_read !== 1'b1 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got state=%0d mem_write=%b mem_read=%b illegal=%b want 0/0/1/0",
                         state, mem_write, mem_read, illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    run_instr(6'h09, 1, 0, -1, c, r, b);
    n_checks++;
    if (c !== 5 || r !== 1) begin
      n_fail++; $display("FAIL post_reset_fetch: got cycles=%0d retires=%0d want 5/1", c, r);
    end
  endtask

  initial begin
    test_reset();
    test_addiu();
    test_lw_wait();
    test_branch();
    test_back_to_back();
    test_random();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
